// File: rtl/vga_board_capture_pkg.sv
// Purpose : shared VGA timing, board geometry and pinout constants for the board capture path.
// Latency : n/a (constants, types and helpers only).
// Backpressure: n/a.
package vga_board_capture_pkg;

  // 640x480 timing, one pixel per clk
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_TOTAL   = 525;

  // Board geometry on screen
  localparam int BOARD_DIM   = 8;
  localparam int BOARD_BITS  = BOARD_DIM * BOARD_DIM;
  localparam int CELL_SIZE   = 48;
  localparam int ORIGIN_X    = 128;
  localparam int ORIGIN_Y    = 48;
  localparam int LOCK_FRAMES = 2;

  // vga_in pinout {hsync, b0, g0, r0, vsync, b1, g1, r1}; syncs active-low
  localparam int HSYNC_BIT = 7;
  localparam int VSYNC_BIT = 3;

  localparam logic [5:0] RGB_BLACK = 6'b000000;
  localparam logic [5:0] RGB_WHITE = 6'b111111;

  typedef enum logic [1:0] {
    SEARCH,
    TRAIN,
    LOCKED
  } lock_state_e;

  // Pixel coordinate of the centre of cell idx along one axis
  function automatic int cell_centre(input int origin, input int size, input int idx);
    return origin + size * idx + size / 2;
  endfunction

endpackage

// File: rtl/vga_board_capture_timing.sv
// Purpose : recover h/v position from hsync/vsync edges, check line/frame periods, lock FSM.
// Latency : vga_in registered once; h/v/rgb are aligned to that registered stream.
// Backpressure: none, the video stream cannot be stalled.
// Ports   : clk, reset (sync, active-high), vga_in[7:0] -> rgb[5:0], h, v, locked, frame_tick
//           (frame_tick pulses the cycle after a good vsync edge while locked).
module vga_timing_recover #(
  parameter int H_VISIBLE   = vga_board_capture_pkg::H_VISIBLE,
  parameter int H_FRONT     = vga_board_capture_pkg::H_FRONT,
  parameter int H_TOTAL     = vga_board_capture_pkg::H_TOTAL,
  parameter int V_VISIBLE   = vga_board_capture_pkg::V_VISIBLE,
  parameter int V_FRONT     = vga_board_capture_pkg::V_FRONT,
  parameter int V_TOTAL     = vga_board_capture_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = vga_board_capture_pkg::LOCK_FRAMES,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    vga_in,
  output logic [5:0]    rgb,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          locked,
  output logic          frame_tick
);
  import vga_board_capture_pkg::*;

  // Period counters get headroom so they can saturate above the nominal total
  localparam int HPW = $clog2(H_TOTAL + 1) + 1;
  localparam int VPW = $clog2(V_TOTAL + 1) + 1;
  localparam logic [HW-1:0] H_LOAD = HW'(H_VISIBLE + H_FRONT);
  localparam logic [VW-1:0] V_LOAD = VW'(V_VISIBLE + V_FRONT);

  logic [7:0]     pix;
  lock_state_e    state;
  logic [HPW-1:0] clk_cnt;
  logic [VPW-1:0] line_cnt;
  logic           h_seen, v_seen;
  logic [3:0]     good_cnt;
  logic           hs_fall, vs_fall, h_ok, v_ok, h_bad, v_bad;

  // Edges are taken between the incoming sample and the register, so counter
  // updates land in the same cycle the edge appears on the registered stream.
  assign hs_fall = pix[HSYNC_BIT] & ~vga_in[HSYNC_BIT];
  assign vs_fall = pix[VSYNC_BIT] & ~vga_in[VSYNC_BIT];
  assign rgb     = {pix[6:4], pix[2:0]};

  // A line edge coincident with the frame edge closes the frame it ends.
  assign h_ok  = h_seen && (clk_cnt == HPW'(H_TOTAL - 1));
  assign v_ok  = v_seen && ((line_cnt + VPW'(hs_fall)) == VPW'(V_TOTAL));
  assign h_bad = hs_fall && !h_ok;
  assign v_bad = vs_fall && !v_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix        <= '0;
      h          <= '0;
      v          <= '0;
      clk_cnt    <= '0;
      line_cnt   <= '0;
      h_seen     <= 1'b0;
      v_seen     <= 1'b0;
      good_cnt   <= '0;
      state      <= SEARCH;
      locked     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pix <= vga_in;

      if (hs_fall)                    h <= H_LOAD;
      else if (h == HW'(H_TOTAL - 1)) h <= '0;
      else                            h <= h + 1'b1;

      // vsync load takes priority over the line increment
      if (vs_fall)      v <= V_LOAD;
      else if (hs_fall) v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;

      if (hs_fall) begin
        clk_cnt <= '0;
        h_seen  <= 1'b1;
      end else if (clk_cnt != '1) begin
        clk_cnt <= clk_cnt + 1'b1;
      end

      if (vs_fall) begin
        line_cnt <= '0;
        v_seen   <= 1'b1;
      end else if (hs_fall && line_cnt != '1) begin
        line_cnt <= line_cnt + 1'b1;
      end

      frame_tick <= 1'b0;
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state    <= TRAIN;
            good_cnt <= '0;
          end
        end
        TRAIN: begin
          if (h_bad || v_bad) begin
            state <= SEARCH;
          end else if (vs_fall) begin
            // The edge that opened training is the first of LOCK_FRAMES
            // consecutive sync edges; good_cnt counts the good ones after it.
            if (int'(good_cnt) + 2 >= LOCK_FRAMES) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (h_bad || v_bad) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end else if (vs_fall) begin
            frame_tick <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_board_capture.sv
// Purpose : sample the centre pixel of each 8x8 board cell off the VGA bus and publish a board per frame.
// Latency : board/board_valid update one cycle after a good vsync edge on the registered stream.
// Backpressure: none; board_valid is a pulse and board holds until the next publish.
// Ports   : clk, reset (sync, active-high), vga_in[7:0] ->
//           board[63:0] (bit row*8+col, 1 = alive), board_valid, board_changed, frame_error, locked.
module vga_board_capture #(
  parameter int H_VISIBLE   = vga_board_capture_pkg::H_VISIBLE,
  parameter int H_FRONT     = vga_board_capture_pkg::H_FRONT,
  parameter int H_TOTAL     = vga_board_capture_pkg::H_TOTAL,
  parameter int V_VISIBLE   = vga_board_capture_pkg::V_VISIBLE,
  parameter int V_FRONT     = vga_board_capture_pkg::V_FRONT,
  parameter int V_TOTAL     = vga_board_capture_pkg::V_TOTAL,
  parameter int CELL_SIZE   = vga_board_capture_pkg::CELL_SIZE,
  parameter int ORIGIN_X    = vga_board_capture_pkg::ORIGIN_X,
  parameter int ORIGIN_Y    = vga_board_capture_pkg::ORIGIN_Y,
  parameter int LOCK_FRAMES = vga_board_capture_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  vga_in,
  output logic [63:0] board,
  output logic        board_valid,
  output logic        board_changed,
  output logic        frame_error,
  output logic        locked
);
  import vga_board_capture_pkg::*;

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [5:0]    rgb;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          frame_tick;

  vga_timing_recover #(
    .H_VISIBLE  (H_VISIBLE),
    .H_FRONT    (H_FRONT),
    .H_TOTAL    (H_TOTAL),
    .V_VISIBLE  (V_VISIBLE),
    .V_FRONT    (V_FRONT),
    .V_TOTAL    (V_TOTAL),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .vga_in    (vga_in),
    .rgb       (rgb),
    .h         (h),
    .v         (v),
    .locked    (locked),
    .frame_tick(frame_tick)
  );

  logic [2:0] col, row;
  logic       col_hit, row_hit;
  logic [5:0] cell_idx;

  // Exactly one pixel per cell matches: the centre column on the centre line.
  always_comb begin
    col     = '0;
    row     = '0;
    col_hit = 1'b0;
    row_hit = 1'b0;
    for (int i = 0; i < BOARD_DIM; i++) begin
      if (h == HW'(cell_centre(ORIGIN_X, CELL_SIZE, i))) begin
        col_hit = 1'b1;
        col     = 3'(i);
      end
      if (v == VW'(cell_centre(ORIGIN_Y, CELL_SIZE, i))) begin
        row_hit = 1'b1;
        row     = 3'(i);
      end
    end
  end

  assign cell_idx = {row, col};

  logic [63:0] shadow;
  logic        err_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow        <= '0;
      err_flag      <= 1'b0;
      board         <= '0;
      board_valid   <= 1'b0;
      board_changed <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      board_valid   <= 1'b0;
      board_changed <= 1'b0;
      if (!locked) begin
        // A partial capture is abandoned; a full locked frame rewrites every
        // shadow bit before the next publish, so only the error flag needs clearing.
        err_flag <= 1'b0;
      end else if (frame_tick) begin
        board         <= shadow;
        board_valid   <= 1'b1;
        board_changed <= (shadow != board);
        frame_error   <= err_flag;
        err_flag      <= 1'b0;
      end else if (col_hit && row_hit) begin
        shadow[cell_idx] <= (rgb == RGB_BLACK);
        if (rgb != RGB_BLACK && rgb != RGB_WHITE) err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_board_capture.sv
// Bench for vga_board_capture on a scaled-down raster (60x48 clocks per frame,
// 4-pixel cells) so that many frames fit in a short run. A driver paints frames
// from per-frame board images; a frame-level model pushes the expected publishes
// into a queue and a monitor pops them whenever board_valid pulses.
module tb_vga_board_capture;

  localparam int HV = 48, HF = 2, HS = 6, HT = 60;
  localparam int VV = 40, VF = 2, VS = 2, VT = 48;
  localparam int CS = 4, OX = 8, OY = 4, LF = 2;
  localparam int NF = 15;
  localparam logic [5:0] YELLOW = 6'b011_001;
  localparam logic [63:0] PATTERN = 64'h0B30_1D49_5840_1148;

  logic        clk, reset;
  logic [7:0]  vga_in;
  logic [63:0] board;
  logic        board_valid, board_changed, frame_error, locked;

  vga_board_capture #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_TOTAL(VT),
    .CELL_SIZE(CS), .ORIGIN_X(OX), .ORIGIN_Y(OY), .LOCK_FRAMES(LF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vga_in       (vga_in),
    .board        (board),
    .board_valid  (board_valid),
    .board_changed(board_changed),
    .frame_error  (frame_error),
    .locked       (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] board;
    logic        changed;
    logic        err;
    int          t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Monitor: every board_valid pulse must match the oldest expected publish.
  always @(negedge clk) begin
    if (!reset && board_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got board %h with nothing expected", board);
      end else begin
        mon_e = exp_q.pop_front();
        check("board", board, mon_e.board);
        check("board_changed", 64'(board_changed), 64'(mon_e.changed));
        check("frame_error", 64'(frame_error), 64'(mon_e.err));
        check("valid_latency", 64'(cyc - mon_e.t), 64'd2);
      end
    end
    if (!reset && board_changed && !board_valid) begin
      errors++;
      $display("FAIL changed_without_valid: got board_changed=1 expected 0");
    end
  end

  // Video generator: syncs active-low, board cells painted black when alive,
  // yellow where requested, white otherwise; blanking is black.
  function automatic logic [7:0] pixel(input int x, input int y,
                                       input logic [63:0] im, input logic [63:0] ye);
    logic       hs, vs;
    logic [5:0] c;
    int         idx;
    hs = !(x >= HV + HF && x < HV + HF + HS);
    vs = !(y >= VV + VF && y < VV + VF + VS);
    c  = 6'b000000;
    if (x < HV && y < VV) begin
      c = 6'b111111;
      if (x >= OX && x < OX + 8 * CS && y >= OY && y < OY + 8 * CS) begin
        idx = ((y - OY) / CS) * 8 + (x - OX) / CS;
        if (ye[idx])      c = YELLOW;
        else if (im[idx]) c = 6'b000000;
      end
    end
    return {hs, c[5:3], vs, c[2:0]};
  endfunction

  logic [63:0] img [NF];
  logic [63:0] yel [NF];
  int          bad_y [NF];
  int          rst_y [NF];

  initial begin
    logic [63:0] last_pub;
    logic        disrupted;
    int          run;
    int          xmax;
    exp_t        e;

    for (int f = 0; f < NF; f++) begin
      img[f]   = {$urandom, $urandom};
      yel[f]   = '0;
      bad_y[f] = -1;
      rst_y[f] = -1;
    end
    for (int f = 0; f < 3; f++) img[f] = '0;
    for (int f = 3; f < 7; f++) img[f] = PATTERN;
    yel[5]   = 64'h1;
    bad_y[7] = 20;
    yel[10]  = 64'h1 << $urandom_range(0, 63);
    rst_y[11] = 20;

    reset  = 1'b1;
    vga_in = 8'h88;
    repeat (3) @(posedge clk);
    #1;
    check("reset_board", board, 64'h0);
    check("reset_valid", 64'(board_valid), 64'h0);
    check("reset_changed", 64'(board_changed), 64'h0);
    check("reset_frame_error", 64'(frame_error), 64'h0);
    check("reset_locked", 64'(locked), 64'h0);

    last_pub  = '0;
    disrupted = 1'b1;
    run       = 0;

    for (int f = 0; f < NF; f++) begin
      for (int y = 0; y < VT; y++) begin
        xmax = (y == bad_y[f]) ? HT - 1 : HT;
        if (y == bad_y[f]) disrupted = 1'b1;
        for (int x = 0; x < xmax; x++) begin
          @(posedge clk);
          #1;
          // Outputs reflect the previous posedge: this is the cycle after reset
          if (y == rst_y[f] && x == 1) begin
            check("midreset_board", board, 64'h0);
            check("midreset_valid", 64'(board_valid), 64'h0);
            check("midreset_changed", 64'(board_changed), 64'h0);
            check("midreset_frame_error", 64'(frame_error), 64'h0);
            check("midreset_locked", 64'(locked), 64'h0);
          end
          vga_in = pixel(x, y, img[f], yel[f]);
          reset  = (y == rst_y[f] && x == 0);
          if (reset) begin
            disrupted = 1'b1;
            last_pub  = '0;
          end
          // Bad line ends one clock early: the next hsync edge is short
          if (bad_y[f] >= 0 && y == bad_y[f] + 1 && x == HV + HF + 2)
            check("locked_drop", 64'(locked), 64'h0);
          if (y == VV + VF && x == 0) begin
            run       = disrupted ? 1 : run + 1;
            disrupted = 1'b0;
            if (run >= LF + 1) begin
              e.board   = img[f] & ~yel[f];
              e.changed = (e.board != last_pub);
              e.err     = (yel[f] != 0);
              e.t       = cyc;
              exp_q.push_back(e);
              last_pub  = e.board;
            end
          end
          if (y == VV + VF && x == 4) begin
            check($sformatf("locked_f%0d", f), 64'(locked), 64'(run >= LF));
            if (run == LF) check($sformatf("board_held_f%0d", f), board, last_pub);
          end
        end
      end
    end

    repeat (10) @(posedge clk);
    #1;
    check("pending_publish", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
